// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: words enter through a valid/ready write port and
// leave as start/data/stop frames, LSB first. Define UART_TX_FIFO_PARITY_EN to add a parity bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ     = 125000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iTxValid,
    input  logic [DATA_BITS-1:0]        iTxByte,
    input  logic                        iParityOdd,
    output logic                        oTxReady,
    output logic                        oTxSerial,
    output logic                        oTxBusy,
    output logic                        oTxDone,
    output logic                        oOverflow,
    output logic [$clog2(FIFO_DEPTH):0] oFifoCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_fifo: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_FIFO_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 ovf_r;
    logic                 push_s;
    logic                 pop_s;

    state_t               state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
    logic [CW-1:0]        cyc_cnt_r, cyc_cnt_s;
    logic                 serial_r, serial_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
`ifdef UART_TX_FIFO_PARITY_EN
    logic                 word_par_r, word_par_s;
    logic                 sense_r, sense_s;
`else
    logic                 unused_parity_s;
    assign unused_parity_s = iParityOdd;
`endif

    // Ready is derived from the registered count, so a full FIFO refuses even during a pop.
    assign oTxReady   = (count_r < DEPTH_C);
    assign push_s     = iTxValid && oTxReady;
    assign oFifoCount = count_r;
    assign oOverflow  = ovf_r;
    assign oTxSerial  = serial_r;
    assign oTxBusy    = busy_r;
    assign oTxDone    = done_r;

    // FIFO storage; occupancy is tracked by the pointers, so the array itself is not reset.
    always_ff @(posedge iClk) begin
        if (!iRst && push_s) begin
            mem_r[wr_ptr_r] <= iTxByte;
        end
    end

    // FIFO pointers, occupancy and the dropped-write flag.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
            ovf_r <= iTxValid && !oTxReady;
        end
    end

    // Frame FSM state and the line outputs, registered from the next-state decode.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            cyc_cnt_r  <= {CW{1'b0}};
            serial_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
            word_par_r <= 1'b0;
            sense_r    <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            cyc_cnt_r  <= cyc_cnt_s;
            serial_r   <= serial_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
`ifdef UART_TX_FIFO_PARITY_EN
            word_par_r <= word_par_s;
            sense_r    <= sense_s;
`endif
        end
    end

    // Next-state logic, then output decode of the state being entered.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        cyc_cnt_s = cyc_cnt_r;
        pop_s     = 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
        word_par_s = word_par_r;
        sense_s    = sense_r;
`endif
        case (state_r)
            IDLE: begin
                if (count_r != (AW + 1)'(0)) begin
                    pop_s     = 1'b1;
                    shift_s   = mem_r[rd_ptr_r];
                    bit_cnt_s = {BW{1'b0}};
                    cyc_cnt_s = {CW{1'b0}};
                    state_s   = START;
`ifdef UART_TX_FIFO_PARITY_EN
                    word_par_s = ^mem_r[rd_ptr_r];
                    sense_s    = iParityOdd;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cyc_cnt_s = {CW{1'b0}};
                    state_s   = DATA;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CW'(1);
                end
            end
            DATA: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cyc_cnt_s = {CW{1'b0}};
                    shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == DATA_LAST) begin
`ifdef UART_TX_FIFO_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CW'(1);
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            PARITY: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cyc_cnt_s = {CW{1'b0}};
                    state_s   = STOP;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cyc_cnt_r == STOP_LAST) begin
                    cyc_cnt_s = {CW{1'b0}};
                    state_s   = DONE;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        serial_s = 1'b1;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_s)
            START: begin
                serial_s = 1'b0;
                busy_s   = 1'b1;
            end
            DATA: begin
                serial_s = shift_s[0];
                busy_s   = 1'b1;
            end
`ifdef UART_TX_FIFO_PARITY_EN
            PARITY: begin
                serial_s = word_par_s ^ sense_s;
                busy_s   = 1'b1;
            end
`endif
            STOP: begin
                busy_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                serial_s = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed a scoreboard queue; a negedge monitor
// decodes every frame on the line and checks bits, timing, busy and done against it.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int NB7 = 11;
`else
    localparam int NB7 = 10;
`endif
    localparam int F7 = CPB * NB7;

    logic clk = 1'b0;
    logic rst, valid, parity_odd, valid7;
    logic [DB-1:0] data;
    logic [6:0] data7;
    logic ready, serial, busy, done, ovf;
    logic [$clog2(DEPTH):0] count;
    logic ready7, serial7, busy7, done7, ovf7;
    logic [4:0] count7;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) u_dut (
        .iClk(clk), .iRst(rst), .iTxValid(valid), .iTxByte(data), .iParityOdd(parity_odd),
        .oTxReady(ready), .oTxSerial(serial), .oTxBusy(busy), .oTxDone(done),
        .oOverflow(ovf), .oFifoCount(count));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut7 (
        .iClk(clk), .iRst(rst), .iTxValid(valid7), .iTxByte(data7), .iParityOdd(parity_odd),
        .oTxReady(ready7), .oTxSerial(serial7), .oTxBusy(busy7), .oTxDone(done7),
        .oOverflow(ovf7), .oFifoCount(count7));

    typedef struct {
        logic [DB-1:0] word;
        logic          sense;
        int            wcyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_e;
    int total = 0;
    int bad = 0;
    int cyc_now = 0;
    int in_frame = 0;
    int fcyc = 0;
    int nbits = 0;
    int last_done = -100;
    int exp_start;
    logic [15:0] fb;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_now, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_now++;
        end
    end

    // Monitor: frame decode and line checks for the main DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 0;
                last_done = -100;
            end else if (in_frame == 0) begin
                if (busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        cur_e = sb_q.pop_front();
                        fb = 16'hFFFF;
                        fb[0] = 1'b0;
                        for (int i = 0; i < DB; i++) fb[1 + i] = cur_e.word[i];
                        nbits = 1 + DB;
`ifdef UART_TX_FIFO_PARITY_EN
                        fb[nbits] = (^cur_e.word) ^ cur_e.sense;
                        nbits++;
`endif
                        nbits = nbits + SB;
                        exp_start = (cur_e.wcyc + 2 > last_done + 2) ? cur_e.wcyc + 2 : last_done + 2;
                        check("start_cycle", cyc_now, exp_start);
                        check("start_bit", serial, 0);
                        in_frame = 1;
                        fcyc = 0;
                    end
                end else begin
                    check("idle_line", serial, 1);
                    check("idle_done", done, 0);
                end
            end else begin
                fcyc++;
                if (fcyc < nbits * CPB) begin
                    check("line_bit", serial, fb[fcyc / CPB]);
                    check("frame_busy", busy, 1);
                    check("frame_done", done, 0);
                end else begin
                    check("done_pulse", done, 1);
                    check("done_busy", busy, 0);
                    check("done_line", serial, 1);
                    last_done = cyc_now;
                    in_frame = 0;
                end
            end
        end
    end

    task automatic write(input logic [DB-1:0] w, input logic exp_acc);
        exp_t e;
        check("ready", ready, exp_acc);
        valid = 1'b1;
        data  = w;
        if (exp_acc) begin
            e.word  = w;
            e.sense = parity_odd;
            e.wcyc  = cyc_now;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        check("overflow", ovf, !exp_acc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || in_frame != 0) && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", (sb_q.size() == 0 && in_frame == 0) ? 1 : 0, 1);
        idle(2);
    endtask

    initial begin
        logic [10:0] f7;
        int rel;
        int e_line;
        rst = 1'b1; valid = 1'b1; data = 8'h99; parity_odd = 1'b0;
        valid7 = 1'b0; data7 = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        check("rst_serial", serial, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_count", count, 0);
        check("rst_ready", ready, 1);
        rst = 1'b0;
        idle(3);
        check("no_write_in_rst", count, 0);

        // single frame 0xA5
        write(8'hA5, 1'b1);
        drain(100);

        // parity senses
        parity_odd = 1'b0; write(8'h07, 1'b1); drain(100);
        parity_odd = 1'b1; write(8'h07, 1'b1); drain(100);
        parity_odd = 1'b0; write(8'h00, 1'b1); drain(100);

        // six consecutive writes into a depth-4 FIFO
        write(8'hA1, 1'b1);
        write(8'hA2, 1'b1);
        write(8'hA3, 1'b1);
        write(8'hA4, 1'b1);
        write(8'hA5, 1'b1);
        write(8'hA6, 1'b0);
        check("full_count", count, 4);
        check("full_ready", ready, 0);
        idle(1);
        check("ovf_one_cycle", ovf, 0);
        drain(400);
        check("empty_count", count, 0);

        // back-to-back frames
        write(8'h11, 1'b1);
        write(8'h22, 1'b1);
        drain(200);

        // reset during data bit 3 with a second word queued
        write(8'h3C, 1'b1);
        write(8'hC3, 1'b1);
        idle(16);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        check("midrst_serial", serial, 1);
        check("midrst_count", count, 0);
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        idle(120);
        check("post_rst_count", count, 0);

        // 7 data bits, 2 stop bits, word 0x55
`ifdef UART_TX_FIFO_PARITY_EN
        f7 = 11'b11_0_1010101_0;
`else
        f7 = 11'b0_11_1010101_0;
`endif
        check("ready7", ready7, 1);
        valid7 = 1'b1;
        data7  = 7'h55;
        @(posedge clk); #1;
        valid7 = 1'b0;
        for (int off = 1; off <= F7 + 2; off++) begin
            rel = off - 2;
            if (off < 2) e_line = 1;
            else if (rel < F7) e_line = f7[rel / CPB];
            else e_line = 1;
            check("d7_line", serial7, e_line);
            check("d7_busy", busy7, (off >= 2 && rel < F7) ? 1 : 0);
            check("d7_done", done7, (off == F7 + 2) ? 1 : 0);
            if (off == 1) begin
                check("d7_count_push", count7, 1);
                check("d7_ovf", ovf7, 0);
            end
            if (off == 2) check("d7_count_pop", count7, 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: a FIFO accepts words from the accelerator result path with a valid/ready handshake and serialises them as UART frames with configurable data width, stop-bit count and optional parity. It sits between the result formatter and the board TX pin. It replaces the single-byte transmitter where back-to-back results must be queued without stalling the datapath.

## Interface
- CLK_FREQ, 125000000, clock frequency in Hz
- BAUD_RATE, 115200, line rate
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, cycles per bit; must be ≥2
- DATA_BITS, 8, data bits per frame; legal range 5..9
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2
- iClk  in  1  clock
- iRst  in  1  synchronous reset, active-high
- iTxValid  in  1  write request
- iTxByte  in  DATA_BITS  word to queue
- iParityOdd  in  1  parity sense, 1 = odd, 0 = even; ignored without the macro
- oTxReady  out  1  FIFO can accept a word
- oTxSerial  out  1  serial line, idle high
- oTxBusy  out  1  frame in progress
- oTxDone  out  1  one-cycle pulse at frame end
- oOverflow  out  1  one-cycle pulse when a write is dropped
- oFifoCount  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Write: a word is accepted when iTxValid && oTxReady. oTxReady = (oFifoCount < FIFO_DEPTH), so it is combinational on the registered count.
- iTxValid while oTxReady=0 drops the word and registers oOverflow=1 for the next cycle only. The FIFO contents are unchanged.
- FSM states are IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, latch iParityOdd into a parity-sense register, and go to START. Otherwise stay in IDLE.
- START: line 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: line = shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After bit DATA_BITS-1 completes, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: line = XOR of the popped word, inverted if the latched sense is odd. Lasts CLKS_PER_BIT cycles, then STOP.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then DONE.
- DONE: lasts one cycle with oTxDone=1, then returns to IDLE.
- oTxBusy is 1 in START, DATA, PARITY and STOP. It is 0 in IDLE and DONE.
- oTxSerial is 1 in IDLE and DONE.
- Simultaneous push and pop: count is unchanged, both take effect.
- A push into an empty FIFO cannot pop in the same cycle, because the pop decision uses the registered count.
- When full, a push is refused even if a pop occurs in the same cycle.
- Bit counter width is $clog2(DATA_BITS)+1. Cycle counter width is $clog2(STOP_BITS*CLKS_PER_BIT)+1. FIFO pointers wrap modulo FIFO_DEPTH.
- Illegal parameter values must be trapped by an elaboration-time check (generate error).

## Timing
- Reset values: state IDLE, FIFO empty, oFifoCount=0, oTxReady=1, oTxSerial=1, oTxBusy=0, oTxDone=0, oOverflow=0. Writes are ignored while iRst=1.
- Reset mid-frame: the line is high on the cycle after iRst. All queued words are discarded. oTxDone is not pulsed.
- Latency: write accepted at cycle N. oFifoCount increments at N+1, the word is popped at N+1, and the START line-low begins at N+2.
- Frame length is CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles from START entry to DONE entry, where P=1 with the macro and P=0 without it.
- Back-to-back frames: the next START begins exactly 2 cycles after STOP ends (one DONE cycle plus one IDLE cycle).

## Configuration
- Macro UART_TX_FIFO_PARITY_EN.
- Defined: the PARITY state is present and each frame carries one parity bit set by iParityOdd, sampled at pop.
- Undefined: no PARITY state, iParityOdd is unused, and the frame is start + data + stop.

## Test plan
- Single frame, CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no macro, write 0xA5 at cycle 0:
  - line low cycles 2–5;
  - data 1,0,1,0,0,1,0,1 at 4 cycles each;
  - high stop bit;
  - oTxDone pulse at cycle 42.
- Macro defined, DATA_BITS=8:
  - 0x07 with iParityOdd=0 gives parity bit 1;
  - 0x07 with iParityOdd=1 gives parity bit 0;
  - 0x00 even gives parity bit 0.
- FIFO_DEPTH=4, six writes in consecutive cycles from idle:
  - five are accepted (the first is popped at cycle 1);
  - the sixth is refused with oOverflow=1 for one cycle;
  - five frames go out in order, then oFifoCount=0.
- DATA_BITS=7, STOP_BITS=2, write 0x55:
  - seven data bits 1,0,1,0,1,0,1;
  - line high for 8 cycles before DONE;
  - frame is 40 cycles.
- Two words queued, iRst for one cycle during data bit 3:
  - oTxSerial=1 on the next cycle;
  - oFifoCount=0 and oTxReady=1;
  - no further frames and no oTxDone.
- Writes 0x11 and 0x22 in consecutive cycles: the second START begins 2 cycles after the first frame's STOP ends, and oTxBusy is low only for those 2 cycles.
